// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path.
//   - CLKS_PER_BIT_DEFAULT : default clock cycles per serial bit
//                            (19200 baud from a 100 MHz clock).
//   - rx_state_t           : receiver FSM state encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer that brings the asynchronous serial line into the
//   clk domain. Both flops reset to 1 so that a reset never looks like a
//   start-bit falling edge.
// Ports:
//   clk   in   system clock
//   reset in   synchronous, active-high reset
//   rx    in   asynchronous serial line
//   rx_s  out  synchronized serial line
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver, LSB first. The start bit is confirmed at its middle,
//   then each data bit and the stop bit are sampled one full bit period apart,
//   so every sample lands near the centre of its bit.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   RxD          in   asynchronous serial line, idle high
//   data_ready   in   consumer accepts data_out this cycle
//   data_out     out  last received byte
//   data_valid   out  data_out holds an unconsumed byte
//   frame_error  out  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun      out  one-cycle pulse: byte completed while the previous one
//                     was still unconsumed, new byte dropped
// Handshake: data_out is offered while data_valid is high and stays stable
//   until a cycle with data_valid && data_ready; that cycle transfers the byte
//   and data_valid drops on the next cycle unless a new byte completes in the
//   same cycle, in which case the new byte replaces it and data_valid stays 1.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun
);

    // The timer only ever counts up to CLKS_PER_BIT-1, so clog2 bits suffice.
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_s;
    rx_state_t       state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic bit_end;
    logic half_end;
    logic byte_done;
    logic take;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (RxD),
        .rx_s  (rx_s)
    );

    assign bit_end   = (timer == LAST_TICK);
    assign half_end  = (timer == HALF_TICK);
    // The final data bit is already in shift when the stop bit is sampled.
    assign byte_done = (state == STOP) && bit_end && rx_s;
    assign take      = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (half_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rx_s;
                        timer          <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must go high before a new start.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase

            // Output buffer: load when empty or when being emptied this cycle.
            if (byte_done && (!data_valid || take)) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (take) begin
                data_valid <= 1'b0;
            end

            if (byte_done && data_valid && !take) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, 5208, clock cycles per serial bit (19200 baud at 100 MHz).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: RxD  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 Port: data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-006 Port: data_out  output  8  last received byte.
REQ-007 Port: data_valid  output  1  data_out holds an unconsumed byte.
REQ-008 Port: frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port: overrun  output  1  one-cycle pulse: byte completed while data_valid high; new byte dropped.

Function
REQ-010 RxD SHALL pass through a 2-flop synchronizer (rx_s); FSM uses only rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: rx_s==0 -> START, bit-timer cleared to 0.
REQ-013 START: timer counts each cycle; at timer==CLKS_PER_BIT/2-1 sample rx_s: 0 -> DATA, timer cleared, bit index 0; 1 -> IDLE (glitch, no output).
REQ-014 DATA: at timer==CLKS_PER_BIT-1 sample rx_s into shift reg bit [index], clear timer, increment index; after index 7 sampled -> STOP.
REQ-015 STOP: at timer==CLKS_PER_BIT-1 sample rx_s: 1 -> byte complete, IDLE; 0 -> frame_error pulse next cycle, byte discarded, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s==1, then IDLE (break conditions never retrigger START).
REQ-017 Byte complete with data_valid==0: data_out loaded, data_valid=1 on the cycle after the stop-bit sample.
REQ-018 Byte complete with data_valid==1 and no handshake that cycle: data_out unchanged, overrun pulses one cycle.
REQ-019 Handshake: data_valid && data_ready clears data_valid next cycle; if a byte completes in the same cycle, the new byte loads and data_valid stays 1, no overrun.
REQ-020 data_out SHALL be stable whenever data_valid==1 until handshake.
REQ-021 Bit timer SHALL be wide enough for CLKS_PER_BIT-1 and never wrap inside a state.
REQ-022 Sampling latency from synchronized start edge to data_valid: CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.

Reset
REQ-023 Reset SHALL force IDLE, timer=0, index=0, synchronizer flops=1, data_out=0x00, data_valid=0, frame_error=0, overrun=0.
REQ-024 Reset mid-frame SHALL discard partial byte; next frame is received only after a fresh falling edge.

Structure
REQ-025 Shared package uart_pkg SHALL hold CLKS_PER_BIT default and the receiver state encoding.
REQ-026 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); remainder in one module.

Verification
REQ-027 Send 0xA5 at CLKS_PER_BIT=5208, data_ready=0 -> data_out=0xA5, data_valid=1 at REQ-022 latency, held.
REQ-028 RxD low 1000 cycles then high -> FSM returns IDLE, no data_valid, no frame_error.
REQ-029 Send 0x3C with stop bit low, then line high -> frame_error one pulse, data_valid stays 0, next 0x55 received correctly.
REQ-030 Send 0x11 then 0x22 back-to-back, data_ready=0 -> data_out=0x11, overrun one pulse at second byte end.
REQ-031 data_ready=1 constantly, send 0x80 -> data_valid high exactly one cycle with data_out=0x80.
REQ-032 Assert reset at data bit 4 of 0xFF, release, send 0x0F -> only 0x0F delivered; all outputs at reset values during reset.
